// File: rtl/mvmpu.sv
// mvmpu: matrix-vector multiply unit, y = A*x, signed integers.
// A and x are read from external memories and y is written back to vector memory.
// MVPE_N MAC lanes each handle one row of a row block, so one pass covers MVPE_N rows.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start / ready     job launch handshake; start is only taken while ready=1
//   matrix_n/m        rows / columns of A (latched at start)
//   addr_rdsv/rdsm    base addresses of x and A; addr_wrsv is the base address for y
//   addr_rdm/rdv, rd_en  read requests to the matrix and vector memories
//   din_valid, dm, dv    returned read data, in request order, any latency
//   dout_valid, sdout, addr_wrv  serial write of one result element per cycle
//   dout              all lane results of the current block
//
// Optional build macro MVMPU_SAT_EN: results saturate to the INTWIDTH signed range.
// When it is not defined, results wrap to the low INTWIDTH bits.

module mvmpu_lane #(
   parameter int INTWIDTH = 16,
   parameter int ACCW     = 48
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic [INTWIDTH-1:0] a,
   input  logic [INTWIDTH-1:0] x,
   output logic [INTWIDTH-1:0] res_next
);
   logic signed [ACCW-1:0]       acc, acc_next;
   logic signed [2*INTWIDTH-1:0] prod;

   assign prod     = $signed(a) * $signed(x);
   assign acc_next = en ? acc + {{(ACCW-2*INTWIDTH){prod[2*INTWIDTH-1]}}, prod} : acc;

   // The result is formed from acc_next so that the final beat can land on
   // the same edge that loads the write registers.
`ifdef MVMPU_SAT_EN
   localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-INTWIDTH+1){1'b0}}, {(INTWIDTH-1){1'b1}}};
   localparam logic signed [ACCW-1:0] MINV = {{(ACCW-INTWIDTH+1){1'b1}}, {(INTWIDTH-1){1'b0}}};
   always_comb begin
      if (acc_next > MAXV)      res_next = MAXV[INTWIDTH-1:0];
      else if (acc_next < MINV) res_next = MINV[INTWIDTH-1:0];
      else                      res_next = acc_next[INTWIDTH-1:0];
   end
`else
   assign res_next = acc_next[INTWIDTH-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst || clr) acc <= '0;
      else if (en)    acc <= acc_next;
   end
endmodule

module mvmpu #(
   parameter int MVPE_N   = 4,
   parameter int INTWIDTH = 16,
   parameter int VAW      = 10,
   parameter int MAW      = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       ready,
   input  logic [15:0]                matrix_n,
   input  logic [15:0]                matrix_m,
   input  logic [VAW-1:0]             addr_rdsv,
   input  logic [VAW-1:0]             addr_wrsv,
   input  logic [MAW-1:0]             addr_rdsm,
   output logic [MAW-1:0]             addr_rdm,
   output logic [VAW-1:0]             addr_rdv,
   output logic [VAW-1:0]             addr_wrv,
   output logic                       rd_en,
   input  logic                       din_valid,
   input  logic [MVPE_N*INTWIDTH-1:0] dm,
   input  logic [INTWIDTH-1:0]        dv,
   output logic                       dout_valid,
   output logic [INTWIDTH-1:0]        sdout,
   output logic [MVPE_N*INTWIDTH-1:0] dout
);
   localparam int ACCW = 2*INTWIDTH + 16;
   localparam int LW   = (MVPE_N > 1) ? $clog2(MVPE_N) : 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

   state_t                           state;
   logic [15:0]                      m_r, rows_left, j, cnt, cnt_next, nrows;
   logic [VAW-1:0]                   rdsv_r, wbase;
   logic [MAW-1:0]                   mbase;
   logic [LW-1:0]                    widx;
   logic [MVPE_N-1:0][INTWIDTH-1:0]  res_next, dout_r;
   logic                             accept, clr, last_wr, more, go;

   // rows_left counts rows not yet written, including the current block
   assign nrows    = (rows_left > 16'(MVPE_N)) ? 16'(MVPE_N) : rows_left;
   assign more     = rows_left > 16'(MVPE_N);
   assign last_wr  = (16'(widx) == nrows - 16'd1);
   // beats past m for the current block are dropped
   assign accept   = din_valid && (state == READ || state == DRAIN) && (cnt != m_r);
   assign cnt_next = cnt + {15'd0, accept};
   assign go       = start && ready && (matrix_n != 16'd0) && (matrix_m != 16'd0);
   assign clr      = (state == IDLE && go) || (state == WRITE && last_wr && more);

   for (genvar k = 0; k < MVPE_N; k++) begin : g_lane
      mvmpu_lane #(.INTWIDTH(INTWIDTH), .ACCW(ACCW)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr),
         .en       (accept),
         .a        (dm[k*INTWIDTH +: INTWIDTH]),
         .x        (dv),
         .res_next (res_next[k])
      );
   end

   assign dout = dout_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ready      <= 1'b1;
         rd_en      <= 1'b0;
         dout_valid <= 1'b0;
         addr_rdm   <= '0;
         addr_rdv   <= '0;
         addr_wrv   <= '0;
         sdout      <= '0;
         dout_r     <= '0;
         m_r        <= '0;
         rows_left  <= '0;
         j          <= '0;
         cnt        <= '0;
         rdsv_r     <= '0;
         wbase      <= '0;
         mbase      <= '0;
         widx       <= '0;
      end else begin
         cnt <= cnt_next;
         case (state)
            IDLE: begin
               // ready=0 in IDLE only follows an empty job: one cycle, then back
               if (!ready) ready <= 1'b1;
               else if (start) begin
                  m_r       <= matrix_m;
                  rows_left <= matrix_n;
                  rdsv_r    <= addr_rdsv;
                  wbase     <= addr_wrsv;
                  mbase     <= addr_rdsm;
                  ready     <= 1'b0;
                  if (go) begin
                     state    <= READ;
                     rd_en    <= 1'b1;
                     addr_rdm <= addr_rdsm;
                     addr_rdv <= addr_rdsv;
                     j        <= '0;
                     cnt      <= '0;
                  end
               end
            end
            READ: begin
               if (j == m_r - 16'd1) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  j        <= j + 16'd1;
                  addr_rdm <= addr_rdm + MAW'(1);
                  addr_rdv <= addr_rdv + VAW'(1);
               end
            end
            DRAIN: begin
               if (cnt_next == m_r) begin
                  state      <= WRITE;
                  dout_valid <= 1'b1;
                  dout_r     <= res_next;
                  sdout      <= res_next[0];
                  addr_wrv   <= wbase;
                  widx       <= '0;
               end
            end
            WRITE: begin
               if (last_wr) begin
                  dout_valid <= 1'b0;
                  if (more) begin
                     state     <= READ;
                     rows_left <= rows_left - 16'(MVPE_N);
                     mbase     <= mbase + MAW'(m_r);
                     wbase     <= wbase + VAW'(MVPE_N);
                     rd_en     <= 1'b1;
                     addr_rdm  <= mbase + MAW'(m_r);
                     addr_rdv  <= rdsv_r;
                     j         <= '0;
                     cnt       <= '0;
                  end else begin
                     state <= IDLE;
                     ready <= 1'b1;
                  end
               end else begin
                  widx     <= widx + LW'(1);
                  sdout    <= dout_r[widx + LW'(1)];
                  addr_wrv <= addr_wrv + VAW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mvmpu.sv
// Self-checking bench for mvmpu: directed cases plus randomized jobs against a
// row/column reference model, with a memory model of configurable latency and gaps.
module tb_mvmpu;
   localparam int N = 4, W = 16, VAW = 10, MAW = 12;

   logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic             ready, rd_en, dout_valid;
   logic             din_valid;
   logic [15:0]      matrix_n = '0, matrix_m = '0;
   logic [VAW-1:0]   addr_rdsv = '0, addr_wrsv = '0, addr_rdv, addr_wrv;
   logic [MAW-1:0]   addr_rdsm = '0, addr_rdm;
   logic [N*W-1:0]   dm, dout;
   logic [W-1:0]     dv, sdout;

   mvmpu #(.MVPE_N(N), .INTWIDTH(W), .VAW(VAW), .MAW(MAW)) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready),
      .matrix_n(matrix_n), .matrix_m(matrix_m),
      .addr_rdsv(addr_rdsv), .addr_wrsv(addr_wrsv), .addr_rdsm(addr_rdsm),
      .addr_rdm(addr_rdm), .addr_rdv(addr_rdv), .addr_wrv(addr_wrv), .rd_en(rd_en),
      .din_valid(din_valid), .dm(dm), .dv(dv),
      .dout_valid(dout_valid), .sdout(sdout), .dout(dout)
   );

   initial forever #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int A [0:15][0:15];
   int xv [0:15];
   int jn, jm, jrdsm, jrdsv, lat = 1, rd_idx = 0, cyc = 0;
   bit gap_en = 1'b0;
   logic [N*W-1:0] mmem [0:4095];
   logic [W-1:0]   vmem [0:1023];

   typedef struct { logic [N*W-1:0] m; logic [W-1:0] v; int due; } beat_t;
   typedef struct { logic [VAW-1:0] a; logic [W-1:0] v; logic [N*W-1:0] d; } wr_t;
   beat_t bq[$];
   wr_t   wr_q[$];

   task automatic chk(input string tag, input longint got, input longint exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_y(input int i);
      longint s = 0;
      for (int j = 0; j < jm; j++) s += longint'(A[i][j]) * longint'(xv[j]);
`ifdef MVMPU_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      return s[15:0];
   endfunction

   // Lay A out in row blocks and x contiguously; lanes past row n hold junk.
   task automatic load(input int n, input int m, input int rdsv, input int rdsm);
      int nb;
      nb = (n + N - 1) / N;
      jn = n; jm = m; jrdsm = rdsm; jrdsv = rdsv;
      for (int b = 0; b < nb; b++)
         for (int j = 0; j < m; j++) begin
            logic [N*W-1:0] w;
            for (int k = 0; k < N; k++)
               w[k*W +: W] = (b*N + k < n) ? 16'(A[b*N+k][j]) : 16'($urandom);
            mmem[(rdsm + b*m + j) % 4096] = w;
         end
      for (int j = 0; j < m; j++) vmem[(rdsv + j) % 1024] = 16'(xv[j]);
   endtask

   // Memory model: a request seen at a rising edge returns lat cycles later,
   // in order, optionally with random idle gaps. Also logs writes.
   initial begin
      din_valid = 1'b0; dm = '0; dv = '0;
      forever begin
         @(negedge clk);
         cyc++;
         din_valid = 1'b0;
         dm = {$urandom, $urandom};
         dv = 16'($urandom);
         if (rst) bq.delete();
         else begin
            if (bq.size() > 0 && bq[0].due <= cyc && !(gap_en && $urandom_range(0, 2) == 0)) begin
               din_valid = 1'b1;
               dm = bq[0].m;
               dv = bq[0].v;
               void'(bq.pop_front());
            end
            if (rd_en) begin
               if (jm > 0 && rd_idx < ((jn + N - 1) / N) * jm) begin
                  chk("rd_addr_m", addr_rdm, (jrdsm + (rd_idx / jm) * jm + rd_idx % jm) % 4096);
                  chk("rd_addr_v", addr_rdv, (jrdsv + rd_idx % jm) % 1024);
               end
               rd_idx++;
               bq.push_back('{mmem[addr_rdm], vmem[addr_rdv], cyc + lat});
            end
            if (dout_valid) wr_q.push_back('{addr_wrv, sdout, dout});
         end
      end
   end

   task automatic run_job(input int n, input int m, input int rdsv, input int wrsv, input int rdsm,
                          input int l, input bit g, input bit timing, input bit mid);
      int c, first_dv, rdy_at, nb, nw;
      load(n, m, rdsv, rdsm);
      lat = l; gap_en = g;
      nb = (n + N - 1) / N;
      rd_idx = 0;
      wr_q.delete();
      @(posedge clk); #1;
      matrix_n = 16'(n); matrix_m = 16'(m);
      addr_rdsv = VAW'(rdsv); addr_wrsv = VAW'(wrsv); addr_rdsm = MAW'(rdsm);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // inputs after acceptance must not matter
      matrix_n = 16'($urandom); matrix_m = 16'($urandom);
      addr_rdsv = VAW'($urandom); addr_wrsv = VAW'($urandom); addr_rdsm = MAW'($urandom);
      chk("ready_low", ready, 0);
      if (n != 0 && m != 0) chk("rd_en_first", rd_en, 1);
      c = 1; first_dv = 0; rdy_at = 0;
      while (c < 3000) begin
         if (dout_valid && first_dv == 0) first_dv = c;
         if (ready) begin
            rdy_at = c;
            break;
         end
         start = (mid && c == 3);
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      if (rdy_at == 0) chk("timeout", 0, 1);
      if (n == 0 || m == 0) chk("empty_ready_at", rdy_at, 2);
      else if (timing) begin
         chk("first_dout_valid", first_dv, m + 2);
         chk("ready_at", rdy_at, nb * (m + 1) + n + 1);
      end
      chk("rd_count", rd_idx, (n == 0 || m == 0) ? 0 : nb * m);
      nw = (m == 0) ? 0 : n;
      chk("wr_count", wr_q.size(), nw);
      for (int i = 0; i < nw && i < wr_q.size(); i++) begin
         chk("wr_addr", wr_q[i].a, (wrsv + i) % 1024);
         chk("sdout", wr_q[i].v, ref_y(i));
         chk("dout_lane", wr_q[i].d[(i % N)*W +: W], ref_y(i));
      end
      chk("idle_rd_en", rd_en, 0);
      chk("idle_dout_valid", dout_valid, 0);
   endtask

   initial begin
      logic [W-1:0] exp_ovf;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_sdout", sdout, 0);
      chk("rst_addr_rdm", addr_rdm, 0);
      chk("rst_addr_rdv", addr_rdv, 0);
      chk("rst_addr_wrv", addr_wrv, 0);
      rst = 1'b0;

      // 4x3 ramp matrix times all-ones vector
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++) A[i][j] = i*3 + j + 1;
      for (int j = 0; j < 3; j++) xv[j] = 1;
      run_job(4, 3, 100, 200, 300, 1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4 && i < wr_q.size(); i++) chk("ramp_y", wr_q[i].v, 6 + 9*i);

      // two blocks, second one partial
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 2; j++) A[i][j] = int'($urandom_range(0, 65535)) - 32768;
      for (int j = 0; j < 2; j++) xv[j] = int'($urandom_range(0, 65535)) - 32768;
      run_job(6, 2, 10, 20, 40, 1, 1'b0, 1'b1, 1'b0);

      // signed operands, slow memory with gaps, stray start mid-job
      A[0][0] = -3; A[0][1] = 5; xv[0] = 5; xv[1] = -2;
      run_job(1, 2, 5, 7, 9, 3, 1'b1, 1'b0, 1'b1);
      if (wr_q.size() > 0) chk("signed_y", wr_q[0].v, 16'hFFE7);

      // accumulation past the element range
      A[0][0] = 32767; A[0][1] = 32767; xv[0] = 2; xv[1] = 2;
      run_job(1, 2, 1000, 1020, 4090, 1, 1'b0, 1'b1, 1'b0);
`ifdef MVMPU_SAT_EN
      exp_ovf = 16'h7FFF;
`else
      exp_ovf = 16'hFFFC;
`endif
      if (wr_q.size() > 0) chk("overflow_y", wr_q[0].v, exp_ovf);

      // empty jobs
      run_job(0, 5, 1, 2, 3, 1, 1'b0, 1'b1, 1'b0);
      run_job(3, 0, 1, 2, 3, 1, 1'b0, 1'b1, 1'b0);

      // reset in the middle of a job
      load(8, 4, 50, 60);
      lat = 2; gap_en = 1'b0; rd_idx = 0;
      @(posedge clk); #1;
      matrix_n = 16'd8; matrix_m = 16'd4; addr_rdsv = 50; addr_wrsv = 70; addr_rdsm = 60;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_ready", ready, 1);
      chk("abort_rd_en", rd_en, 0);
      chk("abort_dout_valid", dout_valid, 0);
      rst = 1'b0;

      // randomized jobs, bases anywhere so addresses wrap
      for (int t = 0; t < 14; t++) begin
         int n, m, l;
         bit g;
         n = $urandom_range(1, 11);
         m = $urandom_range(1, 9);
         for (int i = 0; i < n; i++)
            for (int j = 0; j < m; j++) A[i][j] = int'($urandom_range(0, 65535)) - 32768;
         for (int j = 0; j < m; j++) xv[j] = int'($urandom_range(0, 65535)) - 32768;
         l = $urandom_range(1, 4);
         g = 1'($urandom_range(0, 1));
         run_job(n, m, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4095),
                 l, g, (l == 1 && !g), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
